reg_bank_reader: RTL and testbench

Read-side sequencer for the small register banks that hold QR-decomposition results, for example the R-matrix entries and the rotated y vector. On a start pulse it walks every bank address from 0 to REG_NUM-1 and captures each word from the bank's combinational read port. It presents the words in order on a valid/ready stream toward the output formatter. When CLR_ON_READ=1 it also zeroes each entry as it is consumed, so the bank is clean for the next subcarrier.

---
 rtl/reg_bank_reader.sv | 145 ++++++++++++++
 tb/tb_reg_bank_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_reader.sv
`timescale 1ns/1ps
// Purpose: streams bank entries 0..REG_NUM-1 from a combinational-read register bank onto a valid/ready port, optionally zeroing each entry as it is captured.
// Latency: first word valid 2 cycles after the start pulse; one word per cycle at full rate; o_done one cycle after the last word is accepted.
// Backpressure: every cycle of o_valid && !i_ready stalls capture and holds o_addr, o_data, o_index and o_last unchanged.
module reg_bank_reader #(
    parameter int DATA_BIT    = 48,
    parameter int REG_NUM     = 4,
    parameter int ADDR_NUM    = 2,
    parameter int CLR_ON_READ = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    output logic                o_busy,
    output logic [ADDR_NUM-1:0] o_addr,
    input  logic [DATA_BIT-1:0] i_rdata,
    output logic                o_we,
    output logic [DATA_BIT-1:0] o_wdata,
    output logic [DATA_BIT-1:0] o_data,
    output logic [ADDR_NUM-1:0] o_index,
    output logic                o_last,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_NUM-1:0] LAST_ADDR = ADDR_NUM'(REG_NUM - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_NUM-1:0] r_cnt;
    logic [ADDR_NUM-1:0] w_cnt_nxt;
    logic                r_busy;
    logic                r_valid;
    logic                r_last;
    logic                r_done;
    logic [DATA_BIT-1:0] r_data;
    logic [ADDR_NUM-1:0] r_index;
    logic                w_slot_free;
    logic                w_accept;
    logic                w_capture;
    logic                w_start_ok;

    // The output slot can take a new word when empty or being drained this edge.
    assign w_slot_free = !r_valid || i_ready;
    assign w_accept    = r_valid && i_ready;
    // A new start is refused during the o_done cycle, while o_busy is still high.
    assign w_start_ok  = (r_state == S_IDLE) && i_start && !r_busy;

    // State and address counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic; capture fires in READ whenever the slot is free.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_start_ok) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (w_slot_free) begin
                    w_capture = 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_cnt_nxt = r_cnt + ADDR_NUM'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (w_accept) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output word register: load on capture, empty on a plain accept, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_data  <= i_rdata;
            r_index <= r_cnt;
            r_last  <= (r_cnt == LAST_ADDR);
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    // Busy spans from the cycle after start through the o_done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && w_accept;
            if (w_start_ok) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    // The bank read port is shared, so the address is always the counter value.
    assign o_addr  = r_cnt;
    assign o_we    = (CLR_ON_READ != 0) ? w_capture : 1'b0;
    assign o_wdata = '0;
    assign o_busy  = r_busy;
    assign o_data  = r_data;
    assign o_index = r_index;
    assign o_last  = r_last;
    assign o_valid = r_valid;
    assign o_done  = r_done;

endmodule

// File: tb/tb_reg_bank_reader.sv
`timescale 1ns/1ps
// Bench for reg_bank_reader: three instances (plain, clear-on-read, single 8-bit entry)
// sharing one clock, each attached to a small behavioural register bank.
// A reference model predicts word order, indices, latency and write-back activity.
module tb_reg_bank_reader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        st    [3];
    logic        rdy   [3];
    logic        busy  [3];
    logic        we    [3];
    logic        last  [3];
    logic        valid [3];
    logic        done  [3];
    logic [1:0]  addr  [3];
    logic [1:0]  index [3];
    logic [47:0] wdata [3];
    logic [47:0] data  [3];
    logic [47:0] rdata [2];

    logic [0:0]  c_addr;
    logic [0:0]  c_index;
    logic [7:0]  c_rdata;
    logic [7:0]  c_wdata;
    logic [7:0]  c_data;

    // Behavioural banks with a one-edge bulk load port.
    logic [47:0] bank [3][4];
    logic        ld   [3];
    logic [47:0] ldv  [3][4];

    // Reference model state.
    logic [47:0] mbank     [3][4];
    logic [47:0] exp_words [3][4];
    int          exp_cnt   [3];
    int          exp_ptr   [3];
    int          stalls    [3];
    int          seen_first[3];
    int          first_cyc [3];
    int          done_cnt  [3];
    int          done_cyc  [3];
    int          we_cnt    [3];
    logic        hold_vld  [3];
    logic [47:0] hold_dat  [3];
    logic [1:0]  hold_adr  [3];
    int          cyc;
    int          total;
    int          bad;

    reg_bank_reader #(.DATA_BIT(48), .REG_NUM(4), .ADDR_NUM(2), .CLR_ON_READ(0)) u_plain (
        .clk(clk), .rst(rst), .i_start(st[0]), .o_busy(busy[0]), .o_addr(addr[0]),
        .i_rdata(rdata[0]), .o_we(we[0]), .o_wdata(wdata[0]), .o_data(data[0]),
        .o_index(index[0]), .o_last(last[0]), .o_valid(valid[0]), .i_ready(rdy[0]),
        .o_done(done[0])
    );

    reg_bank_reader #(.DATA_BIT(48), .REG_NUM(4), .ADDR_NUM(2), .CLR_ON_READ(1)) u_clr (
        .clk(clk), .rst(rst), .i_start(st[1]), .o_busy(busy[1]), .o_addr(addr[1]),
        .i_rdata(rdata[1]), .o_we(we[1]), .o_wdata(wdata[1]), .o_data(data[1]),
        .o_index(index[1]), .o_last(last[1]), .o_valid(valid[1]), .i_ready(rdy[1]),
        .o_done(done[1])
    );

    reg_bank_reader #(.DATA_BIT(8), .REG_NUM(1), .ADDR_NUM(1), .CLR_ON_READ(0)) u_one (
        .clk(clk), .rst(rst), .i_start(st[2]), .o_busy(busy[2]), .o_addr(c_addr),
        .i_rdata(c_rdata), .o_we(we[2]), .o_wdata(c_wdata), .o_data(c_data),
        .o_index(c_index), .o_last(last[2]), .o_valid(valid[2]), .i_ready(rdy[2]),
        .o_done(done[2])
    );

    assign addr[2]  = {1'b0, c_addr};
    assign index[2] = {1'b0, c_index};
    assign data[2]  = {40'd0, c_data};
    assign wdata[2] = {40'd0, c_wdata};
    assign rdata[0] = bank[0][addr[0]];
    assign rdata[1] = bank[1][addr[1]];
    assign c_rdata  = bank[2][c_addr][7:0];

    // Bank storage: bulk load from the bench, or zero write-back from the reader.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ld[d]) begin
                for (int i = 0; i < 4; i++) bank[d][i] <= ldv[d][i];
            end else if (we[d]) begin
                bank[d][addr[d]] <= '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int nreg(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    // Per-cycle observation of every instance, run mid-cycle.
    task automatic monitor();
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                hold_vld[d] = 1'b0;
            end else begin
                if (hold_vld[d]) begin
                    chk("hold_data", data[d], hold_dat[d]);
                    chk("hold_addr", 64'(addr[d]), 64'(hold_adr[d]));
                end
                hold_vld[d] = valid[d] && !rdy[d];
                hold_dat[d] = data[d];
                hold_adr[d] = addr[d];
                if (valid[d] && !rdy[d]) stalls[d]++;
                if (valid[d] && seen_first[d] == 0) begin
                    seen_first[d] = 1;
                    first_cyc[d]  = cyc;
                end
                if (valid[d] && rdy[d]) begin
                    if (exp_ptr[d] >= exp_cnt[d]) begin
                        chk("extra_word", 64'(valid[d]), 64'd0);
                    end else begin
                        chk("data", data[d], exp_words[d][exp_ptr[d]]);
                        chk("index", 64'(index[d]), 64'(exp_ptr[d]));
                        chk("last", 64'(last[d]), 64'(exp_ptr[d] == exp_cnt[d] - 1));
                        chk("wdata", wdata[d], 64'd0);
                        exp_ptr[d]++;
                    end
                end
                if (we[d]) begin
                    chk("we_addr", 64'(addr[d]), 64'(we_cnt[d]));
                    we_cnt[d]++;
                end
                if (done[d]) begin
                    done_cnt[d]++;
                    done_cyc[d] = cyc;
                    chk("done_busy", 64'(busy[d]), 64'd1);
                    chk("done_all_words", 64'(exp_ptr[d]), 64'(exp_cnt[d]));
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_zero(input int d);
        chk("rst_busy",  64'(busy[d]),  64'd0);
        chk("rst_addr",  64'(addr[d]),  64'd0);
        chk("rst_we",    64'(we[d]),    64'd0);
        chk("rst_wdata", wdata[d],      64'd0);
        chk("rst_data",  data[d],       64'd0);
        chk("rst_index", 64'(index[d]), 64'd0);
        chk("rst_last",  64'(last[d]),  64'd0);
        chk("rst_valid", 64'(valid[d]), 64'd0);
        chk("rst_done",  64'(done[d]),  64'd0);
    endtask

    task automatic load(input int d, input logic [47:0] v [4]);
        for (int i = 0; i < 4; i++) begin
            ldv[d][i]   = v[i];
            mbank[d][i] = v[i];
        end
        ld[d] = 1'b1;
        tick();
        ld[d] = 1'b0;
    endtask

    task automatic arm(input int d);
        for (int i = 0; i < 4; i++) exp_words[d][i] = mbank[d][i];
        exp_cnt[d]    = nreg(d);
        exp_ptr[d]    = 0;
        stalls[d]     = 0;
        seen_first[d] = 0;
        done_cnt[d]   = 0;
        we_cnt[d]     = 0;
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles on word 1.
    task automatic run_txn(input int d, input int mode, input bit extra_start);
        int c0;
        int n;
        int t;
        n = nreg(d);
        arm(d);
        chk("busy_before_start", 64'(busy[d]), 64'd0);
        c0    = cyc;
        st[d] = 1'b1;
        rdy[d] = 1'b1;
        tick();
        st[d] = 1'b0;
        chk("busy_after_start", 64'(busy[d]), 64'd1);
        t = 0;
        while (done_cnt[d] == 0 && t < 200) begin
            case (mode)
                1:       rdy[d] = ($urandom_range(0, 2) != 0);
                2:       rdy[d] = !(cyc >= c0 + 3 && cyc <= c0 + 5);
                default: rdy[d] = 1'b1;
            endcase
            st[d] = extra_start && (cyc == c0 + 4);
            tick();
            t++;
        end
        st[d]  = 1'b0;
        rdy[d] = 1'b1;
        if (t >= 200) chk("timeout_done", 64'(done_cnt[d]), 64'd1);
        chk("first_latency", 64'(first_cyc[d] - c0), 64'd2);
        chk("done_latency", 64'(done_cyc[d] - c0), 64'(n + 2 + stalls[d]));
        chk("word_count", 64'(exp_ptr[d]), 64'(n));
        chk("we_count", 64'(we_cnt[d]), 64'((d == 1) ? n : 0));
        if (mode == 2) chk("stall_cycles", 64'(stalls[d]), 64'd3);
        chk("busy_dropped", 64'(busy[d]), 64'd0);
        if (extra_start) begin
            tick();
            tick();
            chk("single_done", 64'(done_cnt[d]), 64'd1);
            chk("no_restart", 64'(busy[d]), 64'd0);
        end
        if (d == 1) begin
            for (int i = 0; i < 4; i++) mbank[d][i] = '0;
        end
    endtask

    task automatic reset_mid(input int d);
        int c0;
        arm(d);
        c0     = cyc;
        st[d]  = 1'b1;
        rdy[d] = 1'b1;
        tick();
        st[d] = 1'b0;
        while (cyc < c0 + 4) tick();
        chk("words_before_rst", 64'(exp_ptr[d]), 64'd2);
        rst = 1'b1;
        #1;
        chk_zero(d);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_zero(d);
    endtask

    logic [47:0] vals [4];

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        for (int d = 0; d < 3; d++) begin
            st[d]       = 1'b0;
            rdy[d]      = 1'b1;
            ld[d]       = 1'b0;
            hold_vld[d] = 1'b0;
            arm(d);
            for (int i = 0; i < 4; i++) begin
                ldv[d][i]   = '0;
                mbank[d][i] = '0;
            end
        end
        #12;
        for (int d = 0; d < 3; d++) chk_zero(d);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        vals = '{48'h11, 48'h22, 48'h33, 48'h44};
        load(0, vals);
        load(1, vals);
        vals = '{48'hA5, 48'h0, 48'h0, 48'h0};
        load(2, vals);

        run_txn(0, 0, 1'b0);   // full rate
        run_txn(0, 2, 1'b0);   // 3-cycle stall on word 1, started as busy first drops
        run_txn(0, 0, 1'b1);   // start while busy is ignored; data repeats without clear
        run_txn(1, 0, 1'b0);   // clear-on-read pass
        run_txn(1, 0, 1'b0);   // now streams zeros
        run_txn(2, 0, 1'b0);   // single 8-bit entry
        reset_mid(0);
        run_txn(0, 0, 1'b0);   // restarts from address 0 after reset

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) vals[i] = {16'($urandom), 32'($urandom)};
            load(k % 2, vals);
            run_txn(k % 2, 1, 1'($urandom_range(0, 1)));
            run_txn(k % 2, 1, 1'b0);
        end
        vals = '{48'h5A, 48'h0, 48'h0, 48'h0};
        load(2, vals);
        run_txn(2, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
